multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle control FSM for the MIPS-subset datapath: R-type incl. sll/srl/sra, lw, sw, beq, bne, addi, andi, ori, j. Sequences a shared-memory, single-ALU datapath through fetch/decode/execute/memory/writeback, stalling on a memory ready handshake. Replaces per-instruction combinational control and drives every datapath mux and enable. Emits a retire pulse per completed instruction.

## Interface
- Parameters: none; encodings come from the package.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- OP  in  6  opcode from instruction register, IR[31:26].
- Func  in  6  function field, IR[5:0].
- Zero  in  1  ALU zero flag, combinational from current ALU inputs.
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  load IR.
- RegDst  out  1  write register: 0 rt, 1 rd.
- MemtoReg  out  1  write data: 0 ALUOut, 1 MDR.
- RegWrite  out  1  register file write enable.
- ALUsrcA  out  2  00 PC, 01 regA, 10 shamt.
- ALUsrcB  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUop  out  3  000 add, 001 sub, 010 funct-decoded, 100 and, 101 or.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- PCWrite  out  1  final PC enable; branch condition already applied.
- retire  out  1  one-cycle pulse on an instruction's last cycle.
- illegal  out  1  unsupported opcode seen in DECODE.
- state  out  4  current state, for debug.

## Operation
- Moore FSM, 4-bit state register. Outputs decode from state; exceptions are PCWrite in BRANCH (uses OP, Zero) and outputs in wait states (use mem_ready). Any signal not listed for a state is 0.
- FETCH (0): MemRead, IorD=0, ALUsrcA=00, ALUsrcB=01, ALUop=000, PCSource=00. IRWrite and PCWrite only when mem_ready. Stay in FETCH while !mem_ready, else go to DECODE.
- DECODE (1): ALUsrcA=00, ALUsrcB=11, add (branch target into ALUOut). Next state by OP:
  - lw/sw → MEM_ADDR
  - R → EXEC_R
  - addi/andi/ori → EXEC_I
  - beq/bne → BRANCH
  - j → JUMP
  - other → FETCH with illegal=1.
- MEM_ADDR (2): ALUsrcA=01, ALUsrcB=10, add. Go to MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ (3): IorD=1, MemRead. Wait for mem_ready, then WB_MEM.
- WB_MEM (4): RegDst=0, MemtoReg=1, RegWrite, retire → FETCH.
- MEM_WRITE (5): IorD=1, MemWrite. On mem_ready assert retire and go to FETCH.
- EXEC_R (6): ALUsrcB=00, ALUop=010. ALUsrcA=10 for Func 000000/000010/000011, else 01 → WB_R.
- WB_R (7): RegDst=1, RegWrite, retire → FETCH.
- EXEC_I (8): ALUsrcA=01, ALUsrcB=10. ALUop 000 for addi, 100 for andi, 101 for ori → WB_I.
- WB_I (9): RegDst=0, RegWrite, retire → FETCH.
- BRANCH (10): ALUsrcA=01, ALUsrcB=00, ALUop=001, PCSource=01. PCWrite = beq ? Zero : ~Zero. Assert retire → FETCH.
- JUMP (11): PCSource=10, PCWrite, retire → FETCH.
- Codes 12–15 are unreachable. If entered, go to FETCH with all outputs 0.

## Timing
- Reset value: state=FETCH. While rst=1, every output is 0 and state reads 0.
- Reset mid-operation aborts immediately and strobes drop in the same cycle. After rst deasserts, FETCH begins on the next edge.
- Latency with mem_ready tied high: lw 5 cycles, sw 4, R 4, I-type 4, beq/bne 3, j 3.
- Each low cycle of mem_ready in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- MemRead/MemWrite and address select stay constant throughout a wait.
- OP/Func are read only in DECODE and later states; IR is stable because IRWrite is asserted only in FETCH.
- retire is asserted exactly once per legal instruction and never for illegal ones.

## Structure
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010
  - shift funct codes
  - ALUop, ALUsrcA/B and PCSource codes.
- One sub-module, mc_op_decode: combinational OP/Func → one-hot instruction class plus is_shift.

## Test plan
- lw (OP=100011), mem_ready=1: states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in cycle 5; one retire.
- FETCH with mem_ready low for 3 cycles: state holds at 0 for 4 cycles. IRWrite/PCWrite pulse only in the 4th cycle.
- beq, Zero=1 → PCWrite=1, PCSource=01 in state 10. bne, Zero=1 → PCWrite=0. retire in both cases.
- sll (OP=0, Func=000000) → ALUsrcA=10 in EXEC_R. add (Func=100000) → ALUsrcA=01. Then RegDst=1, RegWrite in WB_R.
- OP=111111 → illegal=1 in DECODE, then FETCH. No RegWrite/MemWrite/retire.
- rst asserted during MEM_WRITE with mem_ready=0 → MemWrite=0 in the same cycle. state=0 after release; no retire.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// shift functs and the datapath mux/ALU select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_WB_MEM    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_WB_R      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_WB_I      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Bit positions in the one-hot instruction class vector
    localparam int CLS_R    = 0;
    localparam int CLS_LW   = 1;
    localparam int CLS_SW   = 2;
    localparam int CLS_BEQ  = 3;
    localparam int CLS_BNE  = 4;
    localparam int CLS_ADDI = 5;
    localparam int CLS_ANDI = 6;
    localparam int CLS_ORI  = 7;
    localparam int CLS_J    = 8;
    localparam int CLS_W    = 9;

    function automatic logic is_shift_funct(input logic [5:0] func);
        return (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode/funct classifier: one-hot instruction class and a flag
// for shift-by-shamt R-type instructions.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_func,
    output logic [CLS_W-1:0]  o_class,
    output logic              o_is_shift
);

    always_comb begin
        o_class = '0;
        case (i_op)
            OP_R:    o_class[CLS_R]    = 1'b1;
            OP_LW:   o_class[CLS_LW]   = 1'b1;
            OP_SW:   o_class[CLS_SW]   = 1'b1;
            OP_BEQ:  o_class[CLS_BEQ]  = 1'b1;
            OP_BNE:  o_class[CLS_BNE]  = 1'b1;
            OP_ADDI: o_class[CLS_ADDI] = 1'b1;
            OP_ANDI: o_class[CLS_ANDI] = 1'b1;
            OP_ORI:  o_class[CLS_ORI]  = 1'b1;
            OP_J:    o_class[CLS_J]    = 1'b1;
            default: o_class = '0;
        endcase
    end

    assign o_is_shift = o_class[CLS_R] & is_shift_funct(i_func);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the shared-memory, single-ALU MIPS-subset datapath.
// Moore outputs from state, except FETCH/MEM_* handshakes and the BRANCH PC enable.
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OP,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALUop,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    state_t            r_state;
    state_t            w_next;
    logic [CLS_W-1:0]  w_class;
    logic              w_is_shift;

    mc_op_decode u_op_decode (
        .i_op       (OP),
        .i_func     (Func),
        .o_class    (w_class),
        .o_is_shift (w_is_shift)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_class[CLS_LW] || w_class[CLS_SW])
                    w_next = S_MEM_ADDR;
                else if (w_class[CLS_R])
                    w_next = S_EXEC_R;
                else if (w_class[CLS_ADDI] || w_class[CLS_ANDI] || w_class[CLS_ORI])
                    w_next = S_EXEC_I;
                else if (w_class[CLS_BEQ] || w_class[CLS_BNE])
                    w_next = S_BRANCH;
                else if (w_class[CLS_J])
                    w_next = S_JUMP;
                else
                    w_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (w_class[CLS_LW])
                    w_next = S_MEM_READ;
                else if (w_class[CLS_SW])
                    w_next = S_MEM_WRITE;
                else
                    w_next = S_FETCH;
            end
            S_MEM_READ:  w_next = mem_ready ? S_WB_MEM : S_MEM_READ;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    w_next = S_WB_R;
            S_EXEC_I:    w_next = S_WB_I;
            default:     w_next = S_FETCH;
        endcase
    end

    // Outputs are forced low while rst is high so strobes drop without waiting for a clock.
    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUsrcA  = SRCA_PC;
        ALUsrcB  = SRCB_REG;
        ALUop    = ALU_ADD;
        PCSource = PCS_ALU;
        PCWrite  = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUsrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUsrcB = SRCB_IMM_SH;
                    illegal = ~(|w_class);
                end
                S_MEM_ADDR: begin
                    ALUsrcA = SRCA_REG;
                    ALUsrcB = SRCB_IMM;
                end
                S_MEM_READ: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_WB_MEM: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_MEM_WRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    retire   = mem_ready;
                end
                S_EXEC_R: begin
                    ALUsrcA = w_is_shift ? SRCA_SHAMT : SRCA_REG;
                    ALUop   = ALU_FUNCT;
                end
                S_WB_R: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_EXEC_I: begin
                    ALUsrcA = SRCA_REG;
                    ALUsrcB = SRCB_IMM;
                    if (w_class[CLS_ANDI])
                        ALUop = ALU_AND;
                    else if (w_class[CLS_ORI])
                        ALUop = ALU_OR;
                    else
                        ALUop = ALU_ADD;
                end
                S_WB_I: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUsrcA  = SRCA_REG;
                    ALUop    = ALU_SUB;
                    PCSource = PCS_ALUOUT;
                    PCWrite  = w_class[CLS_BEQ] ? Zero : ~Zero;
                    retire   = 1'b1;
                end
                S_JUMP: begin
                    PCSource = PCS_JUMP;
                    PCWrite  = 1'b1;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control word against hand-computed values.
module tb_multi_cycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] OP;
    logic [5:0] Func;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic [1:0] ALUsrcA, ALUsrcB, PCSource;
    logic [2:0] ALUop;
    logic       PCWrite, retire, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .OP        (OP),
        .Func      (Func),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ALUop     (ALUop),
        .PCSource  (PCSource),
        .PCWrite   (PCWrite),
        .retire    (retire),
        .illegal   (illegal),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,A,B,ALUop,PCSrc,PCWrite,retire,illegal,state}
    logic [22:0] obs;
    assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUsrcA, ALUsrcB, ALUop, PCSource, PCWrite, retire, illegal, state};

    function automatic logic [22:0] mk(input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] aop, input logic [1:0] pcs,
                                       input logic pcw, input logic ret, input logic ill,
                                       input logic [3:0] st);
        return {iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcw, ret, ill, st};
    endfunction

    logic [22:0] F_RDY, F_WAIT, DEC, DEC_ILL, MADDR, MRD, WBM, MWR_WAIT, MWR_RDY;
    logic [22:0] EXR_SH, EXR, WBR, EXI_ORI, EXI_ANDI, EXI_ADDI, WBI, BR_T, BR_N, JMP, ZERO;

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [22:0] exp);
        #1;
        chk(tag, obs, exp);
        @(negedge clk);
    endtask

    initial begin
        F_RDY    = mk(0,1,0,1,0,0,0,2'b00,2'b01,3'b000,2'b00,1,0,0,4'd0);
        F_WAIT   = mk(0,1,0,0,0,0,0,2'b00,2'b01,3'b000,2'b00,0,0,0,4'd0);
        DEC      = mk(0,0,0,0,0,0,0,2'b00,2'b11,3'b000,2'b00,0,0,0,4'd1);
        DEC_ILL  = mk(0,0,0,0,0,0,0,2'b00,2'b11,3'b000,2'b00,0,0,1,4'd1);
        MADDR    = mk(0,0,0,0,0,0,0,2'b01,2'b10,3'b000,2'b00,0,0,0,4'd2);
        MRD      = mk(1,1,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,0,4'd3);
        WBM      = mk(0,0,0,0,0,1,1,2'b00,2'b00,3'b000,2'b00,0,1,0,4'd4);
        MWR_WAIT = mk(1,0,1,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0,0,4'd5);
        MWR_RDY  = mk(1,0,1,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,1,0,4'd5);
        EXR_SH   = mk(0,0,0,0,0,0,0,2'b10,2'b00,3'b010,2'b00,0,0,0,4'd6);
        EXR      = mk(0,0,0,0,0,0,0,2'b01,2'b00,3'b010,2'b00,0,0,0,4'd6);
        WBR      = mk(0,0,0,0,1,0,1,2'b00,2'b00,3'b000,2'b00,0,1,0,4'd7);
        EXI_ORI  = mk(0,0,0,0,0,0,0,2'b01,2'b10,3'b101,2'b00,0,0,0,4'd8);
        EXI_ANDI = mk(0,0,0,0,0,0,0,2'b01,2'b10,3'b100,2'b00,0,0,0,4'd8);
        EXI_ADDI = mk(0,0,0,0,0,0,0,2'b01,2'b10,3'b000,2'b00,0,0,0,4'd8);
        WBI      = mk(0,0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,0,1,0,4'd9);
        BR_T     = mk(0,0,0,0,0,0,0,2'b01,2'b00,3'b001,2'b01,1,1,0,4'd10);
        BR_N     = mk(0,0,0,0,0,0,0,2'b01,2'b00,3'b001,2'b01,0,1,0,4'd10);
        JMP      = mk(0,0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b10,1,1,0,4'd11);
        ZERO     = '0;

        rst = 1'b1; OP = 6'b100011; Func = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1 chk("reset_outputs", obs, ZERO);
        @(negedge clk);
        rst = 1'b0;

        // lw, no wait states: 0,1,2,3,4
        cyc("lw_fetch", F_RDY);
        cyc("lw_decode", DEC);
        cyc("lw_memaddr", MADDR);
        cyc("lw_memread", MRD);
        cyc("lw_wbmem", WBM);

        // sw with 3 stall cycles in FETCH and 1 in MEM_WRITE
        OP = 6'b101011; mem_ready = 1'b0;
        cyc("fetch_wait1", F_WAIT);
        cyc("fetch_wait2", F_WAIT);
        cyc("fetch_wait3", F_WAIT);
        mem_ready = 1'b1;
        cyc("fetch_ready", F_RDY);
        cyc("sw_decode", DEC);
        cyc("sw_memaddr", MADDR);
        mem_ready = 1'b0;
        cyc("sw_memwrite_wait", MWR_WAIT);
        mem_ready = 1'b1;
        cyc("sw_memwrite_rdy", MWR_RDY);

        // lw with one stall in MEM_READ
        OP = 6'b100011;
        cyc("lw2_fetch", F_RDY);
        cyc("lw2_decode", DEC);
        cyc("lw2_memaddr", MADDR);
        mem_ready = 1'b0;
        cyc("lw2_memread_wait", MRD);
        mem_ready = 1'b1;
        cyc("lw2_memread_rdy", MRD);
        cyc("lw2_wbmem", WBM);

        // branches
        OP = 6'b000100; Zero = 1'b1;
        cyc("beq_fetch", F_RDY);
        cyc("beq_decode", DEC);
        cyc("beq_taken", BR_T);
        OP = 6'b000101;
        cyc("bne_fetch", F_RDY);
        cyc("bne_decode", DEC);
        cyc("bne_zero1", BR_N);
        OP = 6'b000100; Zero = 1'b0;
        cyc("beq0_fetch", F_RDY);
        cyc("beq0_decode", DEC);
        cyc("beq_not_taken", BR_N);
        OP = 6'b000101;
        cyc("bne0_fetch", F_RDY);
        cyc("bne0_decode", DEC);
        cyc("bne_taken", BR_T);

        // R-type: shifts use shamt, add uses regA
        OP = 6'b000000; Func = 6'b000000;
        cyc("sll_fetch", F_RDY);
        cyc("sll_decode", DEC);
        cyc("sll_exec", EXR_SH);
        cyc("sll_wb", WBR);
        Func = 6'b100000;
        cyc("add_fetch", F_RDY);
        cyc("add_decode", DEC);
        cyc("add_exec", EXR);
        cyc("add_wb", WBR);
        Func = 6'b000011;
        cyc("sra_fetch", F_RDY);
        cyc("sra_decode", DEC);
        cyc("sra_exec", EXR_SH);
        cyc("sra_wb", WBR);
        Func = 6'b000010;
        cyc("srl_fetch", F_RDY);
        cyc("srl_decode", DEC);
        cyc("srl_exec", EXR_SH);
        cyc("srl_wb", WBR);

        // I-type
        OP = 6'b001101;
        cyc("ori_fetch", F_RDY);
        cyc("ori_decode", DEC);
        cyc("ori_exec", EXI_ORI);
        cyc("ori_wb", WBI);
        OP = 6'b001100;
        cyc("andi_fetch", F_RDY);
        cyc("andi_decode", DEC);
        cyc("andi_exec", EXI_ANDI);
        cyc("andi_wb", WBI);
        OP = 6'b001000;
        cyc("addi_fetch", F_RDY);
        cyc("addi_decode", DEC);
        cyc("addi_exec", EXI_ADDI);
        cyc("addi_wb", WBI);

        // jump
        OP = 6'b000010;
        cyc("j_fetch", F_RDY);
        cyc("j_decode", DEC);
        cyc("j_jump", JMP);

        // illegal opcode: flagged in DECODE, straight back to FETCH
        OP = 6'b111111;
        cyc("ill_fetch", F_RDY);
        cyc("ill_decode", DEC_ILL);
        cyc("ill_refetch", F_RDY);

        // reset during a stalled MEM_WRITE
        OP = 6'b101011;
        cyc("rsw_decode", DEC);
        cyc("rsw_memaddr", MADDR);
        mem_ready = 1'b0;
        #1 chk("rsw_memwrite_wait", obs, MWR_WAIT);
        #1 rst = 1'b1;
        #1 chk("rst_mid_memwrite", obs, ZERO);
        @(negedge clk);
        #1 chk("rst_held", obs, ZERO);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        cyc("post_rst_fetch", F_RDY);
        cyc("post_rst_decode", DEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
